// File: rtl/ucomp_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ucomp_seq_pkg : FSM encoding and size codes for the compare unit   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ucomp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ8  = 2'b00;
  localparam logic [1:0] SZ16 = 2'b01;
  localparam logic [1:0] SZ32 = 2'b10;

  // Index of the most significant byte that takes part in the compare.
  function automatic logic [1:0] top_idx(input logic [1:0] sz);
    case (sz)
      SZ8:     top_idx = 2'd0;
      SZ16:    top_idx = 2'd1;
      default: top_idx = 2'd3;
    endcase
  endfunction

endpackage : ucomp_seq_pkg
`default_nettype wire

// File: rtl/ucomp_seq_cmp8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ucomp8 : 8-bit unsigned magnitude comparator slice                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ucomp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       agb,
  output logic       eq,
  output logic       bga
);

  assign agb = (a > b);
  assign eq  = (a == b);
  assign bga = (a < b);

endmodule : ucomp8
`default_nettype wire

// File: rtl/ucomp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ucomp_seq : byte-serial unsigned compare, MSB byte first, early out|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ucomp_seq
  import ucomp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        agb,
  output logic        eq,
  output logic        bga,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [31:0] a_q, b_q;
  logic [1:0]  size_q;
  logic        agb_q, eq_q, bga_q;

  logic [4:0]  bit_base;
  logic [7:0]  a_byte, b_byte;
  logic        byte_live;
  logic        s_agb, s_eq, s_bga;

  // Bytes above the latched size are forced to zero so they can never decide.
  assign bit_base  = {idx, 3'b000};
  assign byte_live = (idx <= top_idx(size_q));
  assign a_byte    = byte_live ? a_q[bit_base +: 8] : 8'h00;
  assign b_byte    = byte_live ? b_q[bit_base +: 8] : 8'h00;

  ucomp8 u_slice (
    .a   (a_byte),
    .b   (b_byte),
    .agb (s_agb),
    .eq  (s_eq),
    .bga (s_bga)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= 2'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      size_q <= SZ8;
      agb_q  <= 1'b0;
      eq_q   <= 1'b0;
      bga_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            size_q <= size;
            idx    <= top_idx(size);
          end
        end
        ST_CMP: begin
          if (!s_eq) begin
            agb_q <= s_agb;
            bga_q <= s_bga;
            eq_q  <= 1'b0;
          end else if (idx == 2'd0) begin
            agb_q <= 1'b0;
            bga_q <= 1'b0;
            eq_q  <= 1'b1;
          end else begin
            idx <= idx - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_CMP;
      ST_CMP:  if (!s_eq || idx == 2'd0) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_DONE);
    agb       = agb_q;
    eq        = eq_q;
    bga       = bga_q;
  end

endmodule : ucomp_seq
`default_nettype wire

// File: tb/tb_ucomp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ucomp_seq : directed + random checks against a behavioural model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ucomp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  size;
  logic        out_valid;
  logic        out_ready;
  logic        agb, eq, bga, busy;

  int n_vec = 0;
  int n_err = 0;

  ucomp_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .size      (size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .agb       (agb),
    .eq        (eq),
    .bga       (bga),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: compare the size-masked operands numerically; the cycle count is
  // the number of bytes visited from the top selected byte down to the first
  // differing byte (or all of them when equal).
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] sz,
                       output logic e_agb, output logic e_eq, output logic e_bga,
                       output int k);
    int nbytes;
    logic [31:0] mask, am, bm, diff;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    am = ma & mask;
    bm = mb & mask;
    e_agb = (am > bm);
    e_eq  = (am == bm);
    e_bga = (am < bm);
    diff  = am ^ bm;
    k = nbytes;
    for (int i = 0; i < nbytes; i++)
      if ((diff >> (8 * i)) != 32'd0) k = nbytes - i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic [1:0] sz,
                       input int stall);
    logic e_agb, e_eq, e_bga;
    int k, cycles;
    model(oa, ob, sz, e_agb, e_eq, e_bga, k);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    a = oa; b = ob; size = sz; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; size = 2'($urandom);
    cycles = 1;
    while (!out_valid && cycles < 12) begin
      chk("cmp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      cycles++;
    end
    if (!out_valid) begin
      chk("timeout_out_valid", 32'd0, 32'd1);
      out_ready = 1'b0;
      return;
    end
    chk("latency", cycles, k + 1);
    chk("flags", {29'd0, agb, eq, bga}, {29'd0, e_agb, e_eq, e_bga});
    chk("onehot", agb + eq + bga, 32'd1);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_flags", {29'd0, agb, eq, bga}, {29'd0, e_agb, e_eq, e_bga});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_mid_op();
    logic seen;
    a = 32'h1234_5678; b = 32'h1234_5678; size = 2'b10; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_flags", {29'd0, agb, eq, bga}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; size = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, agb, eq, bga}, 32'd0);

    do_op(32'h1234_5678, 32'h1234_5678, 2'b10, 0);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 0);
    do_op(32'hFFFF_FF01, 32'h0000_0002, 2'b00, 0);
    do_op(32'h0000_1234, 32'h0000_1235, 2'b01, 0);
    do_op(32'hABCD_0042, 32'h0000_0042, 2'b11, 3);
    reset_mid_op();
    do_op(32'h0000_00FF, 32'hFFFF_FF00, 2'b00, 1);

    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      rb = ra;
      // Keep most bytes equal so that multi-cycle paths are exercised.
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 2) == 0) rb[8*j +: 8] = 8'($urandom);
      do_op(ra, rb, 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ucomp_seq
`default_nettype wire

// File: doc/ucomp_seq.md
UCOMP_SEQ -- requirements
Module: ucomp_seq

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: request carries a compare operation.
REQ-004 SHALL have port in_ready, output, 1: unit can accept a request; high only in IDLE.
REQ-005 SHALL have port a, input, 32: first operand, unsigned.
REQ-006 SHALL have port b, input, 32: second operand, unsigned.
REQ-007 SHALL have port size, input, 2: 00=8-bit, 01=16-bit, 10=32-bit, 11=treated as 32-bit.
REQ-008 SHALL have port out_valid, output, 1: result is valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port agb, output, 1: a > b.
REQ-011 SHALL have port eq, output, 1: a == b.
REQ-012 SHALL have port bga, output, 1: b > a.
REQ-013 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, CMP and DONE.
REQ-015 SHALL accept a request on in_valid&in_ready, latch a, b and size, load byte index idx = 0/1/3 for size 00/01/1x, and go to CMP.
REQ-016 SHALL, each CMP cycle, compare latched a[idx*8+7:idx*8] against b[idx*8+7:idx*8] using one shared 8-bit unsigned comparator slice (MSB-byte first).
REQ-017 SHALL, when a byte compare is unequal, register agb/bga from that byte, clear eq and go to DONE (early termination).
REQ-018 SHALL, when a byte compare is equal and idx==0, register eq=1, agb=0, bga=0 and go to DONE.
REQ-019 SHALL, when a byte compare is equal and idx!=0, decrement idx and stay in CMP.
REQ-020 SHALL ignore operand bytes above the selected size.
REQ-021 SHALL assert out_valid in DONE, holding agb/eq/bga stable until out_valid&out_ready, then go to IDLE.
REQ-022 SHALL give latency from the accept edge to out_valid of k+1 cycles, where k = number of CMP cycles (1..4).
REQ-023 SHALL ensure exactly one of agb/eq/bga is 1 while out_valid=1.
REQ-024 SHALL hold in_ready=0 in CMP and DONE, so no request is accepted in the same cycle as a result handshake; the earliest next accept is the cycle after the result handshake.
REQ-025 SHALL ignore in_valid when in_ready=0, and ignore out_ready when out_valid=0.

Reset
REQ-026 SHALL, on reset, set state=IDLE, idx=0, out_valid=0, agb=0, eq=0, bga=0, busy=0, and in_ready=1 in the first cycle after reset.
REQ-027 SHALL, on reset mid-operation (CMP or DONE), abort the operation without producing any result; reset has priority over every other event.

Structure
REQ-028 SHALL place the state encoding and the size codes (SZ8/SZ16/SZ32) in the shared execute package.
REQ-029 SHALL reuse the existing ucomp8 as the single comparator sub-module, with the FSM, idx counter and result registers in ucomp_seq.

Verification
REQ-030 SHALL test size=10, a=b=0x12345678, out_ready=1: 4 CMP cycles, out_valid at accept+5, eq=1.
REQ-031 SHALL test size=10, a=0x80000000, b=0x7FFFFFFF: 1 CMP cycle, out_valid at accept+2, agb=1.
REQ-032 SHALL test size=00, a=0xFFFFFF01, b=0x00000002: bga=1 with upper bytes ignored, out_valid at accept+2.
REQ-033 SHALL test size=01, a=0x00001234, b=0x00001235: 2 CMP cycles, bga=1, out_valid at accept+3.
REQ-034 SHALL test out_ready=0 for 3 cycles in DONE: outputs hold and in_ready=0; after the handshake the unit is IDLE next cycle and in_ready=1.
REQ-035 SHALL test reset asserted in the 2nd CMP cycle of a 32-bit compare: next cycle IDLE, out_valid=0, all flags 0, and no result ever appears.
